// File: rtl/bus_pkg.sv
// Shared types and default widths for the bus arbiter and related bus-side blocks.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_arb_state_t;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_MASK_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping around.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  // Pass one looks strictly above the last grant, pass two wraps to the bottom.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_i[k] && (IDX_W'(k) > last_i)) begin
        found = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_i[k]) begin
        found = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
    if (found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus_controller port among NUM_REQ requesters,
// one transaction at a time: IDLE (accept) -> ACCESS (bus cycle(s)) -> RESP (pulse).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]   req_wmask,
  input  logic [NUM_REQ*DATA_W-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic [DATA_W/8-1:0]             bus_wmask,
  output logic [ADDR_W-1:0]               bus_addr,
  output logic [DATA_W-1:0]               bus_wdata,
  input  logic [DATA_W-1:0]               bus_rdata,
  output logic                            busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = $clog2(RD_LATENCY + 1);

  bus_arb_state_t state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [MASK_W-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;

  logic [ADDR_W-1:0]  addr_s  [NUM_REQ];
  logic [MASK_W-1:0]  wmask_s [NUM_REQ];
  logic [DATA_W-1:0]  wdata_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_s[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wmask_s[i] = req_wmask[i*MASK_W +: MASK_W];
    assign wdata_s[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (win_oh),
    .idx_o   (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
      rsp_q     <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata_q   <= rdata_d;
      rsp_q     <= rsp_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // wmask_q doubles as the write flag: it is nonzero only during the write ACCESS cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = '0;
    rdata_d   = rdata_q;
    rsp_d     = '0;
    lat_cnt_d = lat_cnt_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (rst && (|req_valid)) begin
          req_ready = win_oh;
          owner_d   = win_idx;
          last_d    = win_idx;
          addr_d    = addr_s[win_idx];
          wdata_d   = wdata_s[win_idx];
          wmask_d   = wmask_s[win_idx];
          lat_cnt_d = CNT_W'(1);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (|wmask_q) begin
          rdata_d         = '0;
          rsp_d[owner_q]  = 1'b1;
          state_d         = RESP;
        end else if (lat_cnt_q == CNT_W'(RD_LATENCY)) begin
          rdata_d         = bus_rdata;
          rsp_d[owner_q]  = 1'b1;
          lat_cnt_d       = '0;
          state_d         = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        addr_d  = '0;
        wdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign bus_wmask = wmask_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (read latency 1 and 3) checked each cycle against a
// transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

  localparam int unsigned NA = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  rv  [2];
  logic [63:0] ra  [2];
  logic [7:0]  rm  [2];
  logic [63:0] rwd [2];
  logic [31:0] brd [2];
  logic [1:0]  rdy [2];
  logic [1:0]  rsv [2];
  logic [31:0] rrd [2];
  logic [3:0]  bwm [2];
  logic [31:0] bad [2];
  logic [31:0] bwd [2];
  logic        bsy [2];

  bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(ra[0]),
    .req_wmask(rm[0]), .req_wdata(rwd[0]), .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]),
    .bus_wmask(bwm[0]), .bus_addr(bad[0]), .bus_wdata(bwd[0]), .bus_rdata(brd[0]), .busy(bsy[0])
  );

  bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(ra[1]),
    .req_wmask(rm[1]), .req_wdata(rwd[1]), .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]),
    .bus_wmask(bwm[1]), .bus_addr(bad[1]), .bus_wdata(bwd[1]), .bus_rdata(brd[1]), .busy(bsy[1])
  );

  int errors = 0;
  int checks = 0;
  int lat [2];
  logic [31:0] atab [NA];
  logic [31:0] bmem [2][NA];
  logic [31:0] mmem [2][NA];

  // model: a transaction record plus cycles elapsed since its accept
  bit          m_idle  [2];
  int          m_last  [2];
  int          m_t     [2];
  int          m_owner [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_mask  [2];

  // bus side: pending write and address age
  bit          pend_v    [2];
  int          pend_idx  [2];
  logic [31:0] pend_data [2];
  logic [3:0]  pend_mask [2];
  int          age       [2];
  logic [31:0] prev_a    [2];

  function automatic int aidx(input logic [31:0] a);
    for (int i = 0; i < NA; i++) if (atab[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int rr_winner(input int last, input logic [1:0] v);
    for (int k = 1; k <= 2; k++) if (v[(last + k) % 2]) return (last + k) % 2;
    return -1;
  endfunction

  function automatic int m_total(input int l);
    return (m_mask[l] != 4'd0) ? 2 : 1 + lat[l];
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %h expected %h at %0t", nm, l, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_idle[l] = 1'b1; m_last[l] = 1; m_t[l] = 0; m_owner[l] = 0;
    end
  endtask

  // Advance the model across one rising edge taken with rst high.
  task automatic model_edge();
    for (int l = 0; l < 2; l++) begin
      if (m_idle[l]) begin
        int w;
        w = rr_winner(m_last[l], rv[l]);
        if (w >= 0) begin
          m_idle[l]  = 1'b0;
          m_t[l]     = 1;
          m_owner[l] = w;
          m_last[l]  = w;
          m_addr[l]  = ra[l][w*32 +: 32];
          m_mask[l]  = rm[l][w*4 +: 4];
          m_wdata[l] = rwd[l][w*32 +: 32];
        end
      end else begin
        if (m_t[l] == 1 && m_mask[l] != 4'd0)
          mmem[l][aidx(m_addr[l])] = merge(mmem[l][aidx(m_addr[l])], m_wdata[l], m_mask[l]);
        if (m_t[l] == m_total(l)) m_idle[l] = 1'b1;
        else m_t[l]++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      if (pend_v[l] && rst) bmem[l][pend_idx[l]] = merge(bmem[l][pend_idx[l]], pend_data[l], pend_mask[l]);
      pend_v[l] = 1'b0;
    end
    if (rst) model_edge();
    else model_reset();
    // read data turns valid only once the address has been held for the read latency
    for (int l = 0; l < 2; l++) begin
      int k;
      if (bad[l] == prev_a[l]) age[l]++;
      else age[l] = 0;
      prev_a[l] = bad[l];
      k = aidx(bad[l]);
      brd[l] = (k >= 0 && age[l] + 1 >= lat[l]) ? bmem[l][k] : 32'hdeadbeef;
    end
  endtask

  task automatic check_all();
    #1;
    for (int l = 0; l < 2; l++) begin
      int w;
      bit in_rsp;
      logic [1:0] er, ey;
      ey = '0;
      er = '0;
      w = (m_idle[l] && rst) ? rr_winner(m_last[l], rv[l]) : -1;
      if (w >= 0) ey[w] = 1'b1;
      in_rsp = !m_idle[l] && (m_t[l] == m_total(l));
      if (in_rsp) er[m_owner[l]] = 1'b1;
      chk("req_ready", l, 32'(rdy[l]), 32'(ey));
      chk("rsp_valid", l, 32'(rsv[l]), 32'(er));
      chk("busy", l, 32'(bsy[l]), 32'(!m_idle[l]));
      chk("bus_addr", l, bad[l], m_idle[l] ? 32'h0 : m_addr[l]);
      chk("bus_wdata", l, bwd[l], m_idle[l] ? 32'h0 : m_wdata[l]);
      chk("bus_wmask", l, 32'(bwm[l]), (!m_idle[l] && m_t[l] == 1) ? 32'(m_mask[l]) : 32'h0);
      if (in_rsp)
        chk("rsp_rdata", l, rrd[l], (m_mask[l] != 4'd0) ? 32'h0 : mmem[l][aidx(m_addr[l])]);
      if (bwm[l] != 4'd0 && aidx(bad[l]) >= 0) begin
        pend_v[l] = 1'b1; pend_idx[l] = aidx(bad[l]);
        pend_data[l] = bwd[l]; pend_mask[l] = bwm[l];
      end
    end
  endtask

  task automatic cyc();
    step();
    check_all();
  endtask

  initial begin
    int g0 [$];
    int g1 [$];
    int o0 [$];
    rst = 1'b0;
    lat[0] = 1;
    lat[1] = 3;
    atab[0] = 32'h10000000; atab[1] = 32'h10000004; atab[2] = 32'h20000010; atab[3] = 32'h2000fffc;
    atab[4] = 32'h80000000; atab[5] = 32'h00000040; atab[6] = 32'hfffffffc; atab[7] = 32'h12345678;
    for (int l = 0; l < 2; l++) begin
      rv[l] = '0; ra[l] = '0; rm[l] = '0; rwd[l] = '0; brd[l] = 32'hdeadbeef;
      pend_v[l] = 1'b0; age[l] = 0; prev_a[l] = '0;
      for (int i = 0; i < NA; i++) begin
        bmem[l][i] = 32'(i) * 32'h01010101;
        mmem[l][i] = 32'(i) * 32'h01010101;
      end
    end
    model_reset();

    // reset held, then released with no requests
    cyc(); cyc();
    chk("t1_busy", 0, 32'(bsy[0]), 32'h0);
    chk("t1_wmask", 0, 32'(bwm[0]), 32'h0);
    step(); rst = 1'b1; check_all();
    cyc(); cyc();

    // req0 write on both lanes
    step();
    for (int l = 0; l < 2; l++) begin
      rv[l] = 2'b01; ra[l][31:0] = 32'h10000000; rm[l][3:0] = 4'b0011; rwd[l][31:0] = 32'hffffffff;
    end
    check_all();
    chk("t2_ready", 0, 32'(rdy[0]), 32'h1);
    step(); rv[0] = '0; rv[1] = '0; check_all();
    chk("t2_wmask", 0, 32'(bwm[0]), 32'h3);
    chk("t2_addr", 0, bad[0], 32'h10000000);
    cyc();
    chk("t2_rsp", 0, 32'(rsv[0]), 32'h1);
    cyc();
    chk("t2_wmask_after", 0, 32'(bwm[0]), 32'h0);
    chk("t2_idle", 0, 32'(bsy[0]), 32'h0);

    // req1 read of the address just written
    step();
    for (int l = 0; l < 2; l++) begin
      rv[l] = 2'b10; ra[l][63:32] = 32'h10000000; rm[l][7:4] = 4'b0000;
    end
    check_all();
    chk("t3_ready", 0, 32'(rdy[0]), 32'h2);
    step(); rv[0] = '0; rv[1] = '0; check_all();
    cyc();
    chk("t3_rsp", 0, 32'(rsv[0]), 32'h2);
    chk("t3_rdata", 0, rrd[0], 32'h0000ffff);
    repeat (4) cyc();

    // both requesters held: grants must alternate
    for (int l = 0; l < 2; l++) begin
      ra[l] = {atab[2], atab[1]}; rm[l] = 8'h0f; rwd[l] = {32'h0, 32'ha5a55a5a};
    end
    for (int c = 0; c < 60 && (g0.size() < 6 || g1.size() < 6); c++) begin
      step();
      if (c == 0) begin rv[0] = 2'b11; rv[1] = 2'b11; end
      check_all();
      if (rdy[0] != 2'b00) g0.push_back(rdy[0][1] ? 1 : 0);
      if (rdy[1] != 2'b00) g1.push_back(rdy[1][1] ? 1 : 0);
      if (rsv[0] != 2'b00) o0.push_back(rsv[0][1] ? 1 : 0);
    end
    chk("t4_grants0", 0, 32'(g0.size() >= 6), 32'h1);
    chk("t4_grants1", 1, 32'(g1.size() >= 6), 32'h1);
    for (int k = 0; k < 6 && k < g0.size(); k++) chk("t4_order", 0, 32'(g0[k]), 32'(k % 2));
    for (int k = 0; k < 6 && k < g1.size(); k++) chk("t4_order", 1, 32'(g1[k]), 32'(k % 2));
    for (int k = 0; k < o0.size(); k++) chk("t4_rsp_owner", 0, 32'(o0[k]), 32'(k % 2));
    step(); rv[0] = '0; rv[1] = '0; check_all();
    repeat (8) cyc();

    // req0 read on the latency-3 lane
    step();
    rv[1] = 2'b01; ra[1][31:0] = atab[3]; rm[1][3:0] = 4'b0000;
    check_all();
    chk("t5_ready", 1, 32'(rdy[1]), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      step(); rv[1] = '0; check_all();
      chk("t5_addr", 1, bad[1], atab[3]);
      chk("t5_no_rsp", 1, 32'(rsv[1]), 32'h0);
    end
    cyc();
    chk("t5_rsp", 1, 32'(rsv[1]), 32'h1);
    chk("t5_rdata", 1, rrd[1], 32'h03030303);
    repeat (2) cyc();

    // reset during the write ACCESS cycle
    step();
    rv[0] = 2'b01; ra[0][31:0] = atab[4]; rm[0][3:0] = 4'hf; rwd[0][31:0] = 32'h12345678;
    check_all();
    step(); rv[0] = '0; check_all();
    chk("t6_wmask_pre", 0, 32'(bwm[0]), 32'hf);
    rst = 1'b0;
    model_reset();
    check_all();
    chk("t6_wmask_rst", 0, 32'(bwm[0]), 32'h0);
    chk("t6_busy_rst", 0, 32'(bsy[0]), 32'h0);
    cyc();
    chk("t6_no_rsp", 0, 32'(rsv[0]), 32'h0);
    step(); rst = 1'b1; check_all();
    chk("t6_no_rsp2", 0, 32'(rsv[0]), 32'h0);
    step();
    for (int l = 0; l < 2; l++) begin
      rv[l] = 2'b11; ra[l] = {atab[5], atab[6]}; rm[l] = 8'h00;
    end
    check_all();
    chk("t6_first_win", 0, 32'(rdy[0]), 32'h1);
    chk("t6_first_win", 1, 32'(rdy[1]), 32'h1);
    step(); rv[0] = '0; rv[1] = '0; check_all();
    repeat (8) cyc();

    // random traffic with occasional reset pulses
    for (int c = 0; c < 1500; c++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 249) == 0) begin
        rst = 1'b0;
        model_reset();
      end
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < 2; i++) begin
          rv[l][i] = ($urandom_range(0, 99) < 60);
          ra[l][i*32 +: 32] = atab[$urandom_range(0, NA - 1)];
          rm[l][i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          rwd[l][i*32 +: 32] = $urandom;
        end
      end
      check_all();
    end
    step(); rst = 1'b1; rv[0] = '0; rv[1] = '0; check_all();
    repeat (8) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
